// File: rtl/dcache_data_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared widths, controller state encoding and data-array output-select
// encodings for the 2-way, 32-set, 128-bit-line D-cache data controller.
// No ports; imported by the interface, the fill buffer and the top.
// ---------------------------------------------------------------------------
package dcache_pkg;

    localparam int INDEX_W = 5;
    localparam int LINE_W  = 128;
    localparam int WORD_W  = 32;
    localparam int BEATS   = 4;
    localparam int BYTES_W = LINE_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        FILL,
        FILL_WR
    } state_t;

    localparam logic [1:0] OE_WAY0 = 2'b01;
    localparam logic [1:0] OE_WAY1 = 2'b10;

    // One-hot output select for the given way.
    function automatic logic [1:0] oeEnc(input logic way);
        return way ? OE_WAY1 : OE_WAY0;
    endfunction

endpackage

// File: rtl/dcache_data_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcache_data_ctrl_if
// Bundles the three buses around the data controller:
//   CPU side   : req_valid/ready/write/way/index/offset/wdata/wstrb,
//                rsp_valid/rsp_rdata
//   Refill side: fill_valid/ready/way/index/data, fill_done
//   Array side : CS, OE, WEB, BWEB, A, DI (to array), DO (from array)
// modport slave  : the controller (serves requests, drives the array pins)
// modport master : the surrounding pipeline, memory and data array
// ---------------------------------------------------------------------------
interface dcache_data_ctrl_if;
    import dcache_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic                req_way;
    logic [INDEX_W-1:0]  req_index;
    logic [1:0]          req_offset;
    logic [WORD_W-1:0]   req_wdata;
    logic [3:0]          req_wstrb;
    logic                rsp_valid;
    logic [WORD_W-1:0]   rsp_rdata;

    logic                fill_valid;
    logic                fill_ready;
    logic                fill_way;
    logic [INDEX_W-1:0]  fill_index;
    logic [WORD_W-1:0]   fill_data;
    logic                fill_done;

    logic                CS;
    logic [1:0]          OE;
    logic [1:0]          WEB;
    logic [BYTES_W-1:0]  BWEB;
    logic [INDEX_W-1:0]  A;
    logic [LINE_W-1:0]   DI;
    logic [LINE_W-1:0]   DO;

    modport slave (
        input  req_valid, req_write, req_way, req_index, req_offset,
               req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata,
        input  fill_valid, fill_way, fill_index, fill_data,
        output fill_ready, fill_done,
        output CS, OE, WEB, BWEB, A, DI,
        input  DO
    );

    modport master (
        output req_valid, req_write, req_way, req_index, req_offset,
               req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata,
        output fill_valid, fill_way, fill_index, fill_data,
        input  fill_ready, fill_done,
        input  CS, OE, WEB, BWEB, A, DI,
        output DO
    );

endinterface

// File: rtl/dcache_data_ctrl_fill_buf.sv
// ---------------------------------------------------------------------------
// dcache_fill_buf
// Assembles a 4-beat refill into a 128-bit line and holds the latched
// way/index used by the array address and output-select.
//   CK, RSTn       : clock, async active-low reset
//   beatAccept_i   : a refill beat is accepted this cycle
//   fillData_i     : beat data
//   fillWay_i/fillIndex_i : refill target, captured on beat 0 only
//   cpuCapture_i   : a CPU access is accepted this cycle
//   cpuWay_i/cpuIndex_i   : CPU target, captured on cpuCapture_i
//   lastBeat_o     : the beat counter points at beat 3
//   line_o         : assembled line
//   way_o/index_o  : latched way and index
// ---------------------------------------------------------------------------
module dcache_fill_buf
    import dcache_pkg::*;
(
    input  logic               CK,
    input  logic               RSTn,
    input  logic               beatAccept_i,
    input  logic [WORD_W-1:0]  fillData_i,
    input  logic               fillWay_i,
    input  logic [INDEX_W-1:0] fillIndex_i,
    input  logic               cpuCapture_i,
    input  logic               cpuWay_i,
    input  logic [INDEX_W-1:0] cpuIndex_i,
    output logic               lastBeat_o,
    output logic [LINE_W-1:0]  line_o,
    output logic               way_o,
    output logic [INDEX_W-1:0] index_o
);

    logic [1:0]         beatCnt_q;
    logic [LINE_W-1:0]  line_q;
    logic               way_q;
    logic [INDEX_W-1:0] index_q;

    // Beat k lands in word k of the line; the counter wraps to 0 after beat 3
    // so the next refill starts clean. Way/index come from beat 0 only, and a
    // CPU access reuses the same latch so a read's way drives OE in RD_WAIT.
    // Fill and CPU accepts are mutually exclusive, fill checked first.
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            beatCnt_q <= '0;
            line_q    <= '0;
            way_q     <= 1'b0;
            index_q   <= '0;
        end else if (beatAccept_i) begin
            for (int k = 0; k < BEATS; k++) begin
                if (beatCnt_q == k[1:0]) begin
                    line_q[k*WORD_W +: WORD_W] <= fillData_i;
                end
            end
            beatCnt_q <= beatCnt_q + 2'd1;
            if (beatCnt_q == 2'd0) begin
                way_q   <= fillWay_i;
                index_q <= fillIndex_i;
            end
        end else if (cpuCapture_i) begin
            way_q   <= cpuWay_i;
            index_q <= cpuIndex_i;
        end
    end

    assign lastBeat_o = (beatCnt_q == 2'(BEATS - 1));
    assign line_o     = line_q;
    assign way_o      = way_q;
    assign index_o    = index_q;

endmodule

// File: rtl/dcache_data_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_data_ctrl
// Initiator-side controller for the 2-way D-cache data array. Turns CPU word
// reads/writes and 4-beat line refills into array WEB/BWEB/A/DI/OE/CS drive
// and returns read words from the array's 1-cycle-latency DO.
//   CK   : clock, rising edge
//   RSTn : asynchronous active-low reset
//   bus  : dcache_data_ctrl_if.slave (CPU, refill and array buses)
// ---------------------------------------------------------------------------
module dcache_data_ctrl
    import dcache_pkg::*;
(
    input  logic              CK,
    input  logic              RSTn,
    dcache_data_ctrl_if.slave bus
);

    state_t             state_q;
    logic               rspValid_q;
    logic [WORD_W-1:0]  rspData_q;
    logic               fillDone_q;
    logic [1:0]         rdOff_q;

    logic               reqFire;
    logic               fillFire;
    logic               lastBeat;
    logic               bufWay;
    logic [INDEX_W-1:0] bufIndex;
    logic [LINE_W-1:0]  lineBuf;
    logic [WORD_W-1:0]  rdWord;

    // A pending refill beat always wins over a CPU request in IDLE.
    assign bus.req_ready  = (state_q == IDLE) && !bus.fill_valid;
    assign bus.fill_ready = (state_q == IDLE) || (state_q == FILL);
    assign reqFire        = bus.req_valid && bus.req_ready;
    assign fillFire       = bus.fill_valid && bus.fill_ready;

    dcache_fill_buf u_fill_buf (
        .CK           (CK),
        .RSTn         (RSTn),
        .beatAccept_i (fillFire),
        .fillData_i   (bus.fill_data),
        .fillWay_i    (bus.fill_way),
        .fillIndex_i  (bus.fill_index),
        .cpuCapture_i (reqFire),
        .cpuWay_i     (bus.req_way),
        .cpuIndex_i   (bus.req_index),
        .lastBeat_o   (lastBeat),
        .line_o       (lineBuf),
        .way_o        (bufWay),
        .index_o      (bufIndex)
    );

    // Word select out of the array line using the offset latched at accept.
    always_comb begin
        rdWord = bus.DO[WORD_W-1:0];
        for (int k = 0; k < BEATS; k++) begin
            if (rdOff_q == k[1:0]) begin
                rdWord = bus.DO[k*WORD_W +: WORD_W];
            end
        end
    end

    // Controller FSM with registered response and fill-done pulses. Reads
    // spend one cycle in RD_WAIT while the array produces DO; writes finish
    // in the accept cycle and never leave IDLE.
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            fillDone_q <= 1'b0;
            rdOff_q    <= '0;
        end else begin
            rspValid_q <= 1'b0;
            fillDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fillFire) begin
                        state_q <= FILL;
                    end else if (reqFire && !bus.req_write) begin
                        state_q <= RD_WAIT;
                        rdOff_q <= bus.req_offset;
                    end
                end
                RD_WAIT: begin
                    rspData_q  <= rdWord;
                    rspValid_q <= 1'b1;
                    state_q    <= IDLE;
                end
                FILL: begin
                    if (fillFire && lastBeat) begin
                        state_q <= FILL_WR;
                    end
                end
                FILL_WR: begin
                    fillDone_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array pin drive. Idle cycles park A/DI/OE on the latched index, line
    // buffer and way. FILL_WR writes the whole line; an accepted CPU access
    // drives the array combinationally in its accept cycle, and a write
    // replicates the word across the line so BWEB alone picks the slot.
    always_comb begin
        bus.CS   = 1'b0;
        bus.WEB  = 2'b11;
        bus.BWEB = '1;
        bus.A    = bufIndex;
        bus.DI   = lineBuf;
        bus.OE   = oeEnc(bufWay);
        if (state_q == FILL_WR) begin
            bus.CS          = 1'b1;
            bus.WEB[bufWay] = 1'b0;
            bus.BWEB        = '0;
        end else if (reqFire) begin
            bus.CS = 1'b1;
            bus.A  = bus.req_index;
            if (bus.req_write) begin
                bus.WEB[bus.req_way] = 1'b0;
                bus.DI               = {BEATS{bus.req_wdata}};
                for (int i = 0; i < BYTES_W; i++) begin
                    if (i[3:2] == bus.req_offset) begin
                        bus.BWEB[i] = !bus.req_wstrb[i[1:0]];
                    end
                end
            end
        end
    end

    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_rdata = rspData_q;
    assign bus.fill_done = fillDone_q;

endmodule

// File: doc/dcache_data_ctrl.md
# dcache_data_ctrl

Initiator-side controller for the 2-way, 32-set, 128-bit-line D-cache data array. It accepts 32-bit word read and write requests from the cache pipeline and 4-beat line refills from the memory side. It translates them into the data array's active-low way-write (WEB), per-byte enable (BWEB), address, data and output-select (OE) signals, and returns read words from the array's 1-cycle-latency DO.

## Interface
Parameters:
- INDEX_W, 5: set index width (A).
- LINE_W, 128: line width (DI/DO).
- WORD_W, 32: request/refill word width.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- RSTn  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  request accepted when `req_valid && req_ready`.
- req_write  in  1  1 = write, 0 = read.
- req_way  in  1  target way.
- req_index  in  5  set index.
- req_offset  in  2  word within line.
- req_wdata  in  32  write data.
- req_wstrb  in  4  byte strobes, active high.
- rsp_valid  out  1  one-cycle pulse: read data valid.
- rsp_rdata  out  32  read word.
- fill_valid  in  1  refill beat valid.
- fill_ready  out  1  beat accepted when `fill_valid && fill_ready`.
- fill_way  in  1  refill way; sampled on beat 0 only.
- fill_index  in  5  refill set; sampled on beat 0 only.
- fill_data  in  32  beat data.
- fill_done  out  1  one-cycle pulse after the line write.
- CS  out  1  1 in any array access cycle.
- OE  out  2  way0 = 2'b01, way1 = 2'b10.
- WEB  out  2  per-way write, active low.
- BWEB  out  16  per-byte write enable, active low.
- A  out  5  array address.
- DI  out  128  array write data.
- DO  in  128  array read data, valid the cycle after the address is presented.

## Operation
States:
- IDLE:
  - `req_ready = !fill_valid`.
  - `fill_ready = 1`.
  - An accepted fill beat 0 goes to FILL with the beat counter at 1.
  - Otherwise an accepted read goes to RD_WAIT.
  - Otherwise an accepted write completes in the same cycle and the state stays IDLE.
- RD_WAIT:
  - `req_ready = 0`, `fill_ready = 0`.
  - OE is held to the latched way.
  - The latched offset selects `DO[32*off +: 32]`, which is registered into rsp_rdata.
  - rsp_valid is set for the next cycle and the state returns to IDLE.
- FILL:
  - `fill_ready = 1`, `req_ready = 0`.
  - Each accepted beat k is placed into `line[32k +: 32]`.
  - On beat 3 the state goes to FILL_WR.
- FILL_WR:
  - `CS = 1`, `WEB[way] = 0` (other way 1), `BWEB = 16'h0000`.
  - A is the latched index and `DI = line`.
  - fill_done pulses the next cycle and the state returns to IDLE.

Array drive on an accepted CPU access in IDLE (combinational, same cycle):
- `CS = 1`, `A = req_index`.
- Read: `WEB = 2'b11`, `BWEB = 16'hFFFF`.
- Write:
  - `WEB[req_way] = 0`.
  - `BWEB[4*req_offset + b] = !req_wstrb[b]`; all other BWEB bits are 1.
  - `DI = {4{req_wdata}}`.

In all other cycles:
- `CS = 0`, `WEB = 2'b11`, `BWEB = 16'hFFFF`.
- `A` = latched index, `DI` = line buffer.
- `OE` = latched way encoding.

## Timing
- Reset values:
  - State IDLE, beat counter 0, line buffer 0, latched way 0, latched index 0.
  - `rsp_valid = 0`, `rsp_rdata = 0`, `fill_done = 0`.
  - `OE = 2'b01`, `WEB = 2'b11`, `BWEB = 16'hFFFF`, `A = 0`, `DI = 0`, `CS = 0`.
- Read latency: accepted in cycle T, DO sampled in T+1, rsp_valid/rsp_rdata in T+2. Next request can be accepted in T+2.
- Write: single cycle, no response. A read accepted in the following cycle returns the new data.
- Refill: 4 accepted beats (gaps allowed), FILL_WR one cycle after beat 3, fill_done the cycle after FILL_WR.
- Simultaneous fill_valid and req_valid in IDLE: the fill wins. The request is held off until IDLE recurs, at the earliest the fill_done cycle.
- Reset mid-fill: the partial line is discarded, with no array write and no fill_done.
- Reset mid-read: no rsp_valid is produced.

## Structure
- dcache_pkg holds:
  - INDEX_W, LINE_W, WORD_W, BEATS = 4.
  - The state enum {IDLE, RD_WAIT, FILL, FILL_WR}.
  - The OE encodings.
- One sub-module, dcache_fill_buf:
  - Contains the 2-bit beat counter, 128-bit line assembly, and way/index capture.
  - Outputs last_beat and line.
- The FSM, read mux and BWEB generation stay in dcache_data_ctrl.

## Test plan
- Reset: hold RSTn low with random inputs, then release.
  - Required: `WEB = 2'b11`, `BWEB = 16'hFFFF`, `CS = 0`, `OE = 2'b01`, `rsp_valid = 0`, `fill_done = 0`, `req_ready = 1` when fill_valid is 0.
- Refill of way1 set 5 with beats 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Required in the FILL_WR cycle: `WEB = 2'b01`, `BWEB = 0`, `A = 5`, `DI = 0x44444444_33333333_22222222_11111111`.
  - Required next cycle: fill_done = 1.
- Read of way1 set 5 offset 2, accepted in T.
  - Required in T+1: `OE = 2'b10`.
  - Required in T+2: `rsp_valid = 1`, `rsp_rdata = 0x33333333`.
- Write of way0 set 3 offset 1, wstrb 4'b0011, wdata 0xAABBCCDD.
  - Required: `WEB = 2'b10`, `BWEB = 16'hFFCF`, `DI = {4{0xAABBCCDD}}`.
  - Read-back of that word: low halfword 0xCCDD, upper halfword unchanged.
- req_valid and fill_valid raised in the same cycle.
  - Required: req_ready stays 0 through the fill; the request is accepted in the fill_done cycle and then completes normally.
- Reset asserted after 2 refill beats, then a fresh 4-beat refill.
  - Required: no WEB low before reset; the FILL_WR cycle writes only the new 4 beats.
